// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: generates the fetch PC, issues single outstanding imem requests
// and buffers returned instructions in a 2-entry queue feeding the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {StIdle, StWait, StFlush} state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] req_pc_q;
    logic [1:0]  count_q;
    logic [31:0] q_pc_q   [2];
    logic [31:0] q_inst_q [2];

    logic        push;
    logic        pop;
    logic        issue;
    logic [1:0]  count_next;
    logic [1:0]  wr_pos;
    logic        wr_idx;

    always_comb begin
        push       = imem_rvalid && (state_q == StWait) && !br;
        pop        = (count_q != 2'd0) && !stall && !br;
        count_next = count_q + {1'b0, push} - {1'b0, pop};
        // Only issue when the post-update queue still has room for the response.
        issue      = rst_n && !br && ((state_q == StIdle) || imem_rvalid)
                     && (count_next < 2'd2);
        wr_pos     = count_q - {1'b0, pop};
        wr_idx     = wr_pos[0];
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;
    assign if_valid  = (count_q != 2'd0);
    assign if_pc     = if_valid ? q_pc_q[0] : 32'h0;
    assign if_inst   = if_valid ? q_inst_q[0] : NOP_INST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0;
            count_q    <= 2'd0;
        end else if (br) begin
            count_q    <= 2'd0;
            fetch_pc_q <= {br_target[31:2], 2'b00};
            // An outstanding fetch whose response is not here yet must be discarded later.
            if ((state_q != StIdle) && !imem_rvalid) begin
                state_q <= StFlush;
            end else begin
                state_q <= StIdle;
            end
        end else begin
            count_q <= count_next;
            if (issue) begin
                req_pc_q   <= fetch_pc_q;
                fetch_pc_q <= fetch_pc_q + 32'd4;
                state_q    <= StWait;
            end else if (imem_rvalid && (state_q != StIdle)) begin
                state_q <= StIdle;
            end
        end
    end

    // Head is always entry 0; a pop shifts entry 1 down, a push lands behind the survivors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pc_q[0]   <= 32'h0;
            q_pc_q[1]   <= 32'h0;
            q_inst_q[0] <= 32'h0;
            q_inst_q[1] <= 32'h0;
        end else begin
            if (pop) begin
                q_pc_q[0]   <= q_pc_q[1];
                q_inst_q[0] <= q_inst_q[1];
            end
            if (push) begin
                q_pc_q[wr_idx]   <= req_pc_q;
                q_inst_q[wr_idx] <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized phase checked
// against an in-order instruction-stream model with a variable-latency memory.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    if_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br          (br),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          lat      = 1;
    int          pops     = 0;
    logic [31:0] key      = 32'h0;
    // Memory model: at most one pending request.
    logic        pend     = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt;
    // Stream model: next PC the consumer must see, next address the fetcher must request.
    logic [31:0] exp_pc    = 32'h0;
    logic [31:0] exp_fetch = 32'h0;
    // Outputs sampled in the last step.
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_pc, o_inst;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic step(input logic st, input logic b, input logic [31:0] tgt);
        logic rv;
        rv = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) rv = 1'b1;
        end
        stall       = st;
        br          = b;
        br_target   = tgt;
        imem_rvalid = rv;
        imem_rdata  = rv ? mem(pend_addr) : $urandom;
        @(negedge clk);
        o_req   = imem_req;
        o_addr  = imem_addr;
        o_valid = if_valid;
        o_pc    = if_pc;
        o_inst  = if_inst;
        if (!rst_n) chk("req_in_reset", {31'h0, o_req}, 32'h0);
        if (b) chk("req_on_br", {31'h0, o_req}, 32'h0);
        if (o_req) begin
            chk("fetch_addr", o_addr, exp_fetch);
            chk("one_outstanding", {31'h0, !pend || rv}, 32'h1);
        end
        if (o_valid) begin
            if (!st && !b) begin
                chk("pop_pc", o_pc, exp_pc);
                chk("pop_inst", o_inst, mem(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end else begin
            chk("empty_pc", o_pc, 32'h0);
            chk("empty_inst", o_inst, 32'h0000_0013);
        end
        if (b) begin
            exp_pc    = {tgt[31:2], 2'b00};
            exp_fetch = {tgt[31:2], 2'b00};
        end else if (o_req) begin
            exp_fetch = exp_fetch + 32'd4;
        end
        if (rv) pend = 1'b0;
        if (o_req && rst_n) begin
            pend      = 1'b1;
            pend_addr = o_addr;
            pend_cnt  = lat;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic next_req(input string tag, output logic [31:0] addr);
        bit found;
        found = 1'b0;
        addr  = 32'hx;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (o_req) begin
                found = 1'b1;
                addr  = o_addr;
            end
        end
        chk(tag, {31'h0, found}, 32'h1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] held_pc;
        bit          seen;

        rst_n = 1'b0; stall = 1'b0; br = 1'b0; br_target = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        #3;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0000_0013);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Streaming with latency 1: one fetch and one instruction per cycle.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("stream_req", {31'h0, o_req}, 32'h1);
            chk("stream_addr", o_addr, 32'(4 * k));
            if (k >= 2) begin
                chk("stream_valid", {31'h0, o_valid}, 32'h1);
                chk("stream_pc", o_pc, 32'(4 * (k - 2)));
                chk("stream_inst", o_inst, 32'(4 * (k - 2)));
            end
        end

        // Stall for 5 cycles: queue fills, fetching stops, head held.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 32'h0);
            if (k == 0) held_pc = o_pc;
            chk("stall_req", {31'h0, o_req}, 32'h0);
            chk("stall_hold", o_pc, held_pc);
            chk("stall_valid", {31'h0, o_valid}, 32'h1);
        end
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0);

        // Latency 3: redirect while fetch of 0x8 is outstanding.
        lat = 3;
        step(1'b0, 1'b1, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (o_req && o_addr == 32'h8) seen = 1'b1;
        end
        chk("saw_req_8", {31'h0, seen}, 32'h1);
        step(1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        chk("flush_no_req", {31'h0, o_req}, 32'h0);
        chk("flush_valid", {31'h0, o_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("flush_req", {31'h0, o_req}, 32'h1);
        chk("flush_addr", o_addr, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (o_valid) begin
                seen = 1'b1;
                chk("target_pc", o_pc, 32'h100);
            end
        end
        chk("target_seen", {31'h0, seen}, 32'h1);

        // Redirect coincident with a response: data dropped, refetch next cycle.
        lat = 1;
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h203);
        step(1'b0, 1'b0, 32'h0);
        chk("coinc_req", {31'h0, o_req}, 32'h1);
        chk("coinc_addr", o_addr, 32'h200);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0);

        // Address wrap at the top of memory.
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        next_req("wrap_req0", a);
        chk("wrap_addr0", a, 32'hFFFF_FFFC);
        next_req("wrap_req1", a);
        chk("wrap_addr1", a, 32'h0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0);

        // Reset with a fetch outstanding; the late response lands during reset.
        lat = 3;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (o_req) seen = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, if_valid}, 32'h0);
        chk("mid_rst_inst", if_inst, 32'h0000_0013);
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        exp_pc    = 32'h0;
        exp_fetch = 32'h0;
        key       = $urandom;
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        chk("post_rst_req", {31'h0, o_req}, 32'h1);
        chk("post_rst_addr", o_addr, 32'h0);

        // Randomized traffic against the stream model.
        pops = 0;
        for (int k = 0; k < 400; k++) begin
            lat = $urandom_range(1, 3);
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), $urandom);
        end
        chk("random_progress", {31'h0, pops > 50}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
